atm_session_ctrl: RTL
=====================

// Module: atm_session_ctrl
// PURPOSE
//  Session sequencer for the ATM datapath. Runs one customer session: card accept, PIN check
//  with retry lockout, language, service menu, amount entry/confirm, balance update, and card
//  eject/retain. It is the single writer of the account balance, with inactivity timeout and cancel.
// PARAMETERS
//  MAX_TRIES    3    wrong-PIN attempts before card retain (1..7)
//  TIMEOUT_CYC  255  idle cycles in any non-IDLE state before forced eject (>=2, fits 16 bits)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  cardno       in   8  card number; nonzero = card present
//  pin          in   4  entered PIN, qualified by pin_valid
//  pin_valid    in   1  one-cycle strobe: PIN entry complete
//  correct_pin  in   4  stored PIN for cardno
//  language     in   1  language choice, sampled in LANG on lang_valid
//  lang_valid   in   1  strobe
//  service      in   2  00 balance, 01 deposit, 10 withdraw, 11 exit; sampled on svc_valid
//  svc_valid    in   1  strobe
//  amount       in   5  deposit/withdraw amount, sampled on amt_valid
//  amt_valid    in   1  strobe
//  confirm      in   1  strobe: yes (CONFIRM/ANOTHER)
//  cancel       in   1  strobe: abort session
//  balance      in   5  account balance from store, sampled on PIN success
//  state_o      out  4  current state encoding
//  lang_o       out  1  latched language
//  bal_o        out  5  session balance register
//  bal_we       out  1  one-cycle write strobe to balance store
//  new_balance  out  5  value to write, valid with bal_we
//  dispense     out  1  one-cycle pulse: pay out amt_o
//  accept_cash  out  1  one-cycle pulse: take in amt_o
//  amt_o        out  5  latched amount
//  err_o        out  2  00 none, 01 insufficient, 10 overflow, 11 zero amount; held until next strobe
//  card_eject   out  1  one-cycle pulse
//  card_retain  out  1  one-cycle pulse
// BEHAVIOUR
//  Reset: state IDLE, tries=0, timer=0, all outputs 0.
//  States (state_o): IDLE 0000, PIN 0010, LANG 0001, SERVICE 0011, AMOUNT 0100,
//   CONFIRM 0111, BALANCE 0110, ANOTHER 0101, EJECT 1000, RETAIN 1001.
//  Transitions are registered; outputs below are registered and pulse in the cycle after the causing edge.
//  IDLE: cardno!=0 -> PIN, tries=0. PIN: pin_valid & pin==correct_pin -> LANG, bal_o<=balance.
//   Mismatch: tries+1. If tries+1==MAX_TRIES -> RETAIN, else stay in PIN.
//  LANG: lang_valid -> lang_o<=language, SERVICE.
//  SERVICE on svc_valid: 00 -> BALANCE; 01/10 -> AMOUNT (kind latched); 11 -> EJECT.
//  AMOUNT on amt_valid: amount==0 -> err=11, stay. Else amt_o<=amount, err=00, CONFIRM.
//  CONFIRM on confirm: withdraw with amt_o>bal_o -> err=01, ANOTHER, no write.
//   Deposit with bal_o+amt_o>31 (6-bit sum) -> err=10, ANOTHER, no write.
//   Otherwise bal_we=1, new_balance=bal_o-/+amt_o, bal_o updated the same cycle,
//   dispense or accept_cash=1, -> ANOTHER.
//  BALANCE: holds 1 cycle (bal_o shown) -> ANOTHER.
//  ANOTHER: confirm -> SERVICE; cancel -> EJECT.
//  EJECT: card_eject=1 for 1 cycle -> IDLE. RETAIN: card_retain=1 for 1 cycle -> IDLE.
//  IDLE is re-entered only when cardno==0 has been seen; a card still present after EJECT/RETAIN waits.
//  Priority, each cycle in a non-IDLE, non-EJECT/RETAIN state: rst > cancel > timeout > strobe.
//   cancel -> EJECT, with no balance write even if confirm is simultaneous.
//  Timer: cleared on any strobe or state change; increments otherwise.
//   Reaching TIMEOUT_CYC -> EJECT. The timer is inactive in IDLE.
//  Card removed (cardno==0) mid-session -> EJECT, then IDLE.
//  Reset mid-session: no bal_we issued; session lost.
//  Strobes arriving in a state that does not consume them are ignored.
// TESTING
//  card 8'h5A, correct PIN, svc=10, amt=7, confirm, bal=20 -> bal_we new_balance=13, dispense, ANOTHER.
//  three wrong PINs (MAX_TRIES=3) -> card_retain pulse on 3rd, IDLE, no bal_we.
//  deposit amt=5 with bal=30 -> err=10, no bal_we; withdraw 9 with bal=8 -> err=01.
//  amt=0 -> err=11, stays in AMOUNT; then amt=3 -> CONFIRM, err cleared.
//  no input for TIMEOUT_CYC cycles in SERVICE -> card_eject; cancel+confirm same cycle in CONFIRM -> eject, no write.
//  rst asserted in CONFIRM -> state 0000, all outputs 0 next cycle.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM customer session sequencer and sole writer of the account balance.
// Three-process FSM; every output is registered and pulses in the cycle after its causing edge.
module atm_session_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cardno,
  input  logic [3:0] pin,
  input  logic       pin_valid,
  input  logic [3:0] correct_pin,
  input  logic       language,
  input  logic       lang_valid,
  input  logic [1:0] service,
  input  logic       svc_valid,
  input  logic [4:0] amount,
  input  logic       amt_valid,
  input  logic       confirm,
  input  logic       cancel,
  input  logic [4:0] balance,
  output logic [3:0] state_o,
  output logic       lang_o,
  output logic [4:0] bal_o,
  output logic       bal_we,
  output logic [4:0] new_balance,
  output logic       dispense,
  output logic       accept_cash,
  output logic [4:0] amt_o,
  output logic [1:0] err_o,
  output logic       card_eject,
  output logic       card_retain
);

  localparam logic [3:0] S_IDLE    = 4'b0000;
  localparam logic [3:0] S_LANG    = 4'b0001;
  localparam logic [3:0] S_PIN     = 4'b0010;
  localparam logic [3:0] S_SERVICE = 4'b0011;
  localparam logic [3:0] S_AMOUNT  = 4'b0100;
  localparam logic [3:0] S_ANOTHER = 4'b0101;
  localparam logic [3:0] S_BALANCE = 4'b0110;
  localparam logic [3:0] S_CONFIRM = 4'b0111;
  localparam logic [3:0] S_EJECT   = 4'b1000;
  localparam logic [3:0] S_RETAIN  = 4'b1001;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  TRIES_LAST = 3'(MAX_TRIES - 1);

  logic [3:0]  state, state_d;
  logic [2:0]  tries, tries_d;
  logic [15:0] timer, timer_d;
  logic        kind_wd, kind_wd_d;
  logic        lang_d, bal_we_d, dispense_d, accept_d, eject_d, retain_d;
  logic [4:0]  bal_d, nb_d, amt_d;
  logic [1:0]  err_d;

  logic        active, abort, timeout, strobe, live, pin_ok, pin_bad;
  logic [5:0]  sum;
  logic [4:0]  diff;

  assign state_o = state;
  assign active  = (state != S_IDLE) && (state != S_EJECT) && (state != S_RETAIN);
  assign abort   = cancel || (cardno == 8'd0);
  assign timeout = (timer == TIMER_LAST);
  assign strobe  = pin_valid || lang_valid || svc_valid || amt_valid || confirm;
  // live: the cycle belongs to normal strobe handling, not to cancel/removal/timeout
  assign live    = active && !abort && !timeout;
  assign pin_ok  = pin_valid && (pin == correct_pin);
  assign pin_bad = pin_valid && (pin != correct_pin);
  assign sum     = {1'b0, bal_o} + {1'b0, amt_o};
  assign diff    = bal_o - amt_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tries       <= 3'd0;
      timer       <= 16'd0;
      kind_wd     <= 1'b0;
      lang_o      <= 1'b0;
      bal_o       <= 5'd0;
      bal_we      <= 1'b0;
      new_balance <= 5'd0;
      dispense    <= 1'b0;
      accept_cash <= 1'b0;
      amt_o       <= 5'd0;
      err_o       <= 2'b00;
      card_eject  <= 1'b0;
      card_retain <= 1'b0;
    end else begin
      state       <= state_d;
      tries       <= tries_d;
      timer       <= timer_d;
      kind_wd     <= kind_wd_d;
      lang_o      <= lang_d;
      bal_o       <= bal_d;
      bal_we      <= bal_we_d;
      new_balance <= nb_d;
      dispense    <= dispense_d;
      accept_cash <= accept_d;
      amt_o       <= amt_d;
      err_o       <= err_d;
      card_eject  <= eject_d;
      card_retain <= retain_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (cardno != 8'd0) state_d = S_PIN;
      // card must be physically removed before a new session may start
      S_EJECT, S_RETAIN: if (cardno == 8'd0) state_d = S_IDLE;
      default: begin
        if (abort || timeout) begin
          state_d = S_EJECT;
        end else begin
          case (state)
            S_PIN: begin
              if (pin_ok) state_d = S_LANG;
              else if (pin_bad && (tries == TRIES_LAST)) state_d = S_RETAIN;
            end
            S_LANG:    if (lang_valid) state_d = S_SERVICE;
            S_SERVICE: begin
              if (svc_valid) begin
                case (service)
                  2'b00:   state_d = S_BALANCE;
                  2'b11:   state_d = S_EJECT;
                  default: state_d = S_AMOUNT;
                endcase
              end
            end
            S_AMOUNT:  if (amt_valid && (amount != 5'd0)) state_d = S_CONFIRM;
            S_CONFIRM: if (confirm) state_d = S_ANOTHER;
            S_BALANCE: state_d = S_ANOTHER;
            S_ANOTHER: if (confirm) state_d = S_SERVICE;
            default:   state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tries_d    = tries;
    kind_wd_d  = kind_wd;
    lang_d     = lang_o;
    bal_d      = bal_o;
    nb_d       = new_balance;
    amt_d      = amt_o;
    err_d      = err_o;
    bal_we_d   = 1'b0;
    dispense_d = 1'b0;
    accept_d   = 1'b0;
    eject_d    = (state_d == S_EJECT)  && (state != S_EJECT);
    retain_d   = (state_d == S_RETAIN) && (state != S_RETAIN);
    timer_d    = (!active || strobe || (state_d != state)) ? 16'd0 : timer + 16'd1;

    if ((state == S_IDLE) && (cardno != 8'd0)) begin
      tries_d = 3'd0;
      err_d   = 2'b00;
    end

    if (live) begin
      if (strobe) err_d = 2'b00;
      case (state)
        S_PIN: begin
          if (pin_ok) bal_d = balance;
          else if (pin_bad) tries_d = tries + 3'd1;
        end
        S_LANG: if (lang_valid) lang_d = language;
        S_SERVICE: if (svc_valid && (service[1] != service[0])) kind_wd_d = service[1];
        S_AMOUNT: begin
          if (amt_valid) begin
            if (amount == 5'd0) err_d = 2'b11;
            else amt_d = amount;
          end
        end
        S_CONFIRM: begin
          if (confirm) begin
            if (kind_wd) begin
              if (amt_o > bal_o) begin
                err_d = 2'b01;
              end else begin
                bal_we_d   = 1'b1;
                nb_d       = diff;
                bal_d      = diff;
                dispense_d = 1'b1;
              end
            end else begin
              if (sum[5]) begin
                err_d = 2'b10;
              end else begin
                bal_we_d = 1'b1;
                nb_d     = sum[4:0];
                bal_d    = sum[4:0];
                accept_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
